// File: rtl/mole_spawner.sv
// -----------------------------------------------------------------------------
// mole_spawner
//   Game-side producer of the mole position for the sprite renderer. A free
//   running LFSR picks one of five holes. The mole stays up for UP_TIME cycles,
//   then a GAP_TIME pause follows. Rising edges on the hole buttons are judged
//   as hit or miss. The block keeps the score and the miss count, and ends the
//   game after MAX_MISSES misses.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous, active-high reset
//   start        in   1  level; a rising edge starts or restarts the game
//   btn          in   5  debounced hole buttons (level); btn[i] = hole i
//   oval_select  out  3  active hole 0-4; 7 = no mole
//   mole_up      out  1  high while a mole is shown
//   hit_pulse    out  1  one-cycle pulse on a successful whack
//   miss_pulse   out  1  one-cycle pulse on a timeout or a wrong button
//   score        out  8  hit count, saturates at 255
//   misses       out  4  miss count
//   game_over    out  1  high once the miss limit is reached
// -----------------------------------------------------------------------------
module mole_spawner #(
  parameter int          UP_TIME    = 25_000_000,
  parameter int          GAP_TIME   = 12_500_000,
  parameter int          MAX_MISSES = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] btn,
  output logic [2:0] oval_select,
  output logic       mole_up,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       game_over
);

  localparam int TMAX = (UP_TIME > GAP_TIME) ? UP_TIME : GAP_TIME;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] UP_LAST    = TW'(UP_TIME - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TIME - 1);
  localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISSES);
  localparam logic [2:0]    NO_MOLE    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Fold 0-7 onto 0-4, then step past the previous hole so that two
  // consecutive moles never share a hole.
  function automatic logic [2:0] pick_hole(input logic [2:0] v, input logic [2:0] prev);
    logic [2:0] c;
    c = (v >= 3'd5) ? v - 3'd5 : v;
    if (c == prev) c = (c == 3'd4) ? 3'd0 : c + 3'd1;
    pick_hole = c;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [15:0]   r_lfsr;
  logic [2:0]    r_prev_oval, w_prev_nxt;
  logic [2:0]    r_oval, w_oval_nxt;
  logic [4:0]    r_btn_q;
  logic          r_start_q;
  logic          r_mole_up;
  logic          r_hit, w_hit_nxt;
  logic          r_miss, w_miss_nxt;
  logic [7:0]    r_score, w_score_nxt;
  logic [3:0]    r_misses, w_misses_nxt;
  logic          r_game_over, w_go_nxt;

  logic [4:0]    w_btn_rise;
  logic [4:0]    w_sel_mask;
  logic          w_start_rise;
  logic          w_wrong;
  logic          w_right;
  logic [3:0]    w_misses_inc;
  logic [2:0]    w_pick;

  assign w_btn_rise   = btn & ~r_btn_q;
  assign w_start_rise = start & ~r_start_q;
  // With no mole up r_oval is 7, the shift falls off the end and the mask is 0.
  assign w_sel_mask   = 5'b00001 << r_oval;
  assign w_wrong      = |(w_btn_rise & ~w_sel_mask);
  assign w_right      = |(w_btn_rise & w_sel_mask);
  assign w_misses_inc = r_misses + 4'd1;
  assign w_pick       = pick_hole(r_lfsr[2:0], r_prev_oval);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_lfsr      <= LFSR_SEED;
      r_prev_oval <= 3'd0;
      r_btn_q     <= 5'd0;
      r_start_q   <= 1'b0;
      r_oval      <= NO_MOLE;
      r_mole_up   <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_score     <= 8'd0;
      r_misses    <= 4'd0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_lfsr      <= lfsr_next(r_lfsr);
      r_prev_oval <= w_prev_nxt;
      r_btn_q     <= btn;
      r_start_q   <= start;
      r_oval      <= w_oval_nxt;
      r_mole_up   <= (w_oval_nxt != NO_MOLE);
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_score     <= w_score_nxt;
      r_misses    <= w_misses_nxt;
      r_game_over <= w_go_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer + TW'(1);
    w_prev_nxt   = r_prev_oval;
    w_oval_nxt   = r_oval;
    w_hit_nxt    = 1'b0;
    w_miss_nxt   = 1'b0;
    w_score_nxt  = r_score;
    w_misses_nxt = r_misses;
    w_go_nxt     = r_game_over;

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        w_oval_nxt  = NO_MOLE;
        if (w_start_rise) begin
          w_state_nxt  = S_GAP;
          w_score_nxt  = 8'd0;
          w_misses_nxt = 4'd0;
        end
      end

      S_GAP: begin
        w_oval_nxt = NO_MOLE;
        if (r_timer == GAP_LAST) begin
          w_state_nxt = S_UP;
          w_oval_nxt  = w_pick;
          w_prev_nxt  = w_pick;
        end
      end

      S_UP: begin
        // A wrong bit outranks a correct one; a correct one outranks the timeout.
        if (w_wrong || (!w_right && (r_timer == UP_LAST))) begin
          w_miss_nxt   = 1'b1;
          w_misses_nxt = w_misses_inc;
          w_oval_nxt   = NO_MOLE;
          if (w_misses_inc == MISS_LIMIT) begin
            w_state_nxt = S_OVER;
            w_go_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_GAP;
          end
        end else if (w_right) begin
          w_hit_nxt   = 1'b1;
          w_score_nxt = sat_inc8(r_score);
          w_oval_nxt  = NO_MOLE;
          w_state_nxt = S_GAP;
        end
      end

      S_OVER: begin
        w_timer_nxt = '0;
        w_oval_nxt  = NO_MOLE;
        if (w_start_rise) begin
          w_state_nxt  = S_GAP;
          w_score_nxt  = 8'd0;
          w_misses_nxt = 4'd0;
          w_go_nxt     = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_oval_nxt  = NO_MOLE;
      end
    endcase

    if (w_state_nxt != r_state) w_timer_nxt = '0;
  end

  assign oval_select = r_oval;
  assign mole_up     = r_mole_up;
  assign hit_pulse   = r_hit;
  assign miss_pulse  = r_miss;
  assign score       = r_score;
  assign misses      = r_misses;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_mole_spawner.sv
module tb_mole_spawner;

  localparam int          UP_T  = 8;
  localparam int          GAP_T = 4;
  localparam int          MAXM  = 3;
  localparam logic [15:0] SEED  = 16'hACE1;

  localparam logic [1:0] EV_UP   = 2'd0;
  localparam logic [1:0] EV_HIT  = 2'd1;
  localparam logic [1:0] EV_MISS = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] btn;
  logic [2:0] oval_select;
  logic       mole_up;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score;
  logic [3:0] misses;
  logic       game_over;

  mole_spawner #(
    .UP_TIME   (UP_T),
    .GAP_TIME  (GAP_T),
    .MAX_MISSES(MAXM),
    .LFSR_SEED (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .btn        (btn),
    .oval_select(oval_select),
    .mole_up    (mole_up),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .score      (score),
    .misses     (misses),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] hole;
    logic [7:0] score;
    logic [3:0] misses;
    logic       go;
  } ev_t;

  ev_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state kept by the stimulus side.
  logic [15:0] m_lfsr;
  logic [2:0]  m_prev;
  logic [7:0]  m_score;
  logic [3:0]  m_misses;

  // Hole statistics observed on the DUT outputs.
  bit seen [5];
  int n_picks   = 0;
  int last_hole = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference LFSR written tap by tap.
  function automatic logic [15:0] ref_lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) begin
      n[15] = 1'b1;
      n[13] = ~n[13];
      n[12] = ~n[12];
      n[10] = ~n[10];
    end
    return n;
  endfunction

  function automatic logic [2:0] ref_pick(input logic [15:0] l, input logic [2:0] prev);
    int c;
    c = int'(l[2:0]);
    if (c >= 5) c = c - 5;
    if (c == int'(prev)) c = (c == 4) ? 0 : c + 1;
    return 3'(c);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= ref_lfsr_step(m_lfsr);
  end

  // Called at the negedge right after the GAP-entry edge; returns at the
  // negedge of the first UP cycle (timer 0).
  task automatic gap_to_up(input bit poke_start, input bit hold_btn, output logic [2:0] hole);
    @(negedge clk);
    if (poke_start) start = 1'b0;
    @(negedge clk);
    if (poke_start) start = 1'b1;
    @(negedge clk);
    chk("gap_no_mole", 32'(oval_select), 32'd7);
    hole   = ref_pick(m_lfsr, m_prev);
    m_prev = hole;
    sb.push_back('{kind: EV_UP, hole: hole, score: m_score, misses: m_misses, go: 1'b0});
    if (hold_btn) btn = 5'b00001 << hole;
    @(negedge clk);
    chk("up_after_gap", 32'(mole_up), 32'd1);
  endtask

  // Press during the UP cycle whose timer equals k.
  task automatic press(input int k, input logic [4:0] mask, input bit is_hit);
    repeat (k) @(negedge clk);
    btn = mask;
    if (is_hit) begin
      m_score = (m_score == 8'd255) ? 8'd255 : m_score + 8'd1;
      sb.push_back('{kind: EV_HIT, hole: 3'd7, score: m_score, misses: m_misses, go: 1'b0});
    end else begin
      m_misses = m_misses + 4'd1;
      sb.push_back('{kind: EV_MISS, hole: 3'd7, score: m_score, misses: m_misses,
                     go: (m_misses == 4'(MAXM))});
    end
    @(negedge clk);
    btn = 5'd0;
  endtask

  task automatic timeout();
    m_misses = m_misses + 4'd1;
    sb.push_back('{kind: EV_MISS, hole: 3'd7, score: m_score, misses: m_misses,
                   go: (m_misses == 4'(MAXM))});
    repeat (UP_T) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    m_score  = 8'd0;
    m_misses = 4'd0;
    chk("start_score", 32'(score), 32'd0);
    chk("start_misses", 32'(misses), 32'd0);
    chk("start_game_over", 32'(game_over), 32'd0);
    chk("start_oval", 32'(oval_select), 32'd7);
  endtask

  // Monitor: pops one expected event whenever the DUT presents one.
  initial begin
    ev_t e;
    bit  prev_up;
    prev_up = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_up   = 1'b0;
        last_hole = -1;
      end else begin
        chk("mole_up_matches_oval", 32'(mole_up), 32'(oval_select != 3'd7));
        if (hit_pulse || miss_pulse || (mole_up && !prev_up)) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: hit=%0d miss=%0d oval=%0d, none expected (t=%0t)",
                     hit_pulse, miss_pulse, oval_select, $time);
          end else begin
            e = sb.pop_front();
            if (mole_up && !prev_up) begin
              chk("ev_kind_up", 32'(hit_pulse || miss_pulse), 32'd0);
              chk("ev_expect_up", 32'(e.kind), 32'(EV_UP));
              chk("mole_hole", 32'(oval_select), 32'(e.hole));
              if (last_hole >= 0) begin
                n_checks++;
                if (int'(oval_select) == last_hole) begin
                  n_fail++;
                  $display("FAIL repeat_hole: got %0d, required differing from %0d",
                           oval_select, last_hole);
                end
              end
              if (oval_select < 3'd5) seen[oval_select] = 1'b1;
              last_hole = int'(oval_select);
              n_picks++;
            end else if (hit_pulse) begin
              chk("ev_expect_hit", 32'(e.kind), 32'(EV_HIT));
              chk("hit_no_miss", 32'(miss_pulse), 32'd0);
              chk("hit_score", 32'(score), 32'(e.score));
              chk("hit_misses", 32'(misses), 32'(e.misses));
              chk("hit_oval", 32'(oval_select), 32'd7);
            end else begin
              chk("ev_expect_miss", 32'(e.kind), 32'(EV_MISS));
              chk("miss_score", 32'(score), 32'(e.score));
              chk("miss_misses", 32'(misses), 32'(e.misses));
              chk("miss_game_over", 32'(game_over), 32'(e.go));
              chk("miss_oval", 32'(oval_select), 32'd7);
            end
          end
        end
        prev_up = mole_up;
      end
    end
  end

  initial begin
    logic [2:0] h;
    rst      = 1'b1;
    start    = 1'b0;
    btn      = 5'd0;
    m_prev   = 3'd0;
    m_score  = 8'd0;
    m_misses = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_oval", 32'(oval_select), 32'd7);
    chk("rst_mole_up", 32'(mole_up), 32'd0);
    chk("rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_misses", 32'(misses), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    rst = 1'b0;

    // Idle with no start.
    repeat (100) begin
      @(negedge clk);
      chk("idle_oval", 32'(oval_select), 32'd7);
      chk("idle_score_pulses", 32'({score, hit_pulse, miss_pulse}), 32'd0);
    end

    // Three unanswered moles end the game.
    do_start();
    for (int i = 0; i < MAXM; i++) begin
      gap_to_up(1'b0, 1'b0, h);
      timeout();
    end
    chk("over_game_over", 32'(game_over), 32'd1);
    chk("over_misses", 32'(misses), 32'(MAXM));
    repeat (6) @(negedge clk);
    chk("over_hold_oval", 32'(oval_select), 32'd7);
    chk("over_hold_go", 32'(game_over), 32'd1);

    // Restart, hit on third UP cycle.
    do_start();
    gap_to_up(1'b0, 1'b0, h);
    press(2, 5'b00001 << h, 1'b1);

    // Correct plus wrong together is a miss.
    gap_to_up(1'b0, 1'b0, h);
    press(1, (5'b00001 << h) | (5'b00001 << ((h + 3'd1) % 3'd5)), 1'b0);

    // Correct press on the last UP cycle beats the timeout.
    gap_to_up(1'b0, 1'b0, h);
    press(UP_T - 1, 5'b00001 << h, 1'b1);

    // Button held across the UP entry edge does not count.
    gap_to_up(1'b0, 1'b1, h);
    timeout();
    btn = 5'd0;

    // Long run of hits; score saturates; a start edge in GAP is ignored.
    for (int i = 0; i < 260; i++) begin
      gap_to_up(i == 3, 1'b0, h);
      press(0, 5'b00001 << h, 1'b1);
    end
    chk("sat_score", 32'(score), 32'd255);

    // Final miss ends the game with score frozen.
    gap_to_up(1'b0, 1'b0, h);
    timeout();
    chk("end_game_over", 32'(game_over), 32'd1);
    repeat (4) @(negedge clk);
    chk("end_score_frozen", 32'(score), 32'd255);

    do_start();

    // Asynchronous reset while a mole is up.
    gap_to_up(1'b0, 1'b0, h);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    #1;
    chk("async_rst_oval", 32'(oval_select), 32'd7);
    chk("async_rst_mole_up", 32'(mole_up), 32'd0);
    m_prev   = 3'd0;
    m_score  = 8'd0;
    m_misses = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    n_checks++;
    if (n_picks < 200) begin
      n_fail++;
      $display("FAIL pick_count: got %0d, required at least 200", n_picks);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("hole_%0d_seen", i), 32'(seen[i]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
